// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared encodings and helpers for the RAM access controller.
//   state_t          - controller FSM states
//   SZ_*             - dp_size encodings (2'b11 is reserved/illegal)
//   PORT_*           - requester ids used by the grant and round-robin pointer
//   access_legal     - alignment / size legality check
//   last_index       - index of the final byte cycle for a size
//   get_byte         - little-endian byte select from a 32-bit word
package ram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    DONE    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DP = 1'b1;

  function automatic logic access_legal(input logic [1:0] size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = (addr_lo[0] == 1'b0);
      SZ_WORD: ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [1:0] last_index(input logic [1:0] size);
    logic [1:0] li;
    case (size)
      SZ_BYTE: li = 2'd0;
      SZ_HALF: li = 2'd1;
      SZ_WORD: li = 2'd3;
      default: li = 2'd0;
    endcase
    return li;
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ram_wait_counter.sv
// ram_wait_counter: wait-state counter for one RAM byte cycle.
//   CLK, RESET_N - clock, async active-low reset
//   clear        - force the count back to 0
//   enable       - count this cycle
//   last         - high during the final wait cycle of a byte (count == WAIT_CYCLES-1)
module ram_wait_counter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic clear,
  input  logic enable,
  output logic last
);

  logic [3:0] cnt_r;

  assign last = enable && (cnt_r == 4'(WAIT_CYCLES - 1));

  // Count 0..WAIT_CYCLES-1 while enabled, wrapping on the last cycle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_r <= 4'd0;
    end else if (clear) begin
      cnt_r <= 4'd0;
    end else if (enable) begin
      cnt_r <= last ? 4'd0 : cnt_r + 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: arbitrates the 256x8 RAM between the instruction-fetch (IF)
// and data (DP) ports and splits half/word accesses into little-endian byte
// cycles of WAIT_CYCLES clocks each.
//   CLK, RESET_N                 - clock, async active-low reset
//   if_req/if_addr               - IF word-read request (held until if_moc)
//   if_moc/if_rdata              - IF completion pulse and read word
//   dp_req/dp_rw/dp_size/dp_addr/dp_wdata - DP request (held until dp_moc)
//   dp_moc/dp_rdata/dp_err       - DP completion pulse, read data, error flag
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata - byte-wide RAM interface
// All outputs are registered; they are computed from next-state values so
// the RAM bus is active in the same cycle the FSM sits in ACCESS.
module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 8
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_moc,
  output logic [31:0]       if_rdata,
  input  logic              dp_req,
  input  logic              dp_rw,
  input  logic [1:0]        dp_size,
  input  logic [ADDR_W-1:0] dp_addr,
  input  logic [31:0]       dp_wdata,
  output logic              dp_moc,
  output logic [31:0]       dp_rdata,
  output logic              dp_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  state_t            state_r, state_s;
  logic              grant_r, grant_s;
  logic              last_port_r, last_port_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [1:0]        size_r, size_s;
  logic              rw_r, rw_s;
  logic [31:0]       wdata_r, wdata_s;
  logic [1:0]        idx_r, idx_s;
  logic [31:0]       result_r, result_s;
  logic              err_r, err_s;
  logic              wait_last_s;

  logic              ram_en_s, ram_we_s, if_moc_s, dp_moc_s, dp_err_s;
  logic [ADDR_W-1:0] ram_addr_s;
  logic [7:0]        ram_wdata_s;
  logic [31:0]       if_rdata_s, dp_rdata_s;

  ram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .clear   (state_r != ACCESS),
    .enable  (state_r == ACCESS),
    .last    (wait_last_s)
  );

  // State and datapath registers plus registered outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r     <= IDLE;
      grant_r     <= PORT_IF;
      last_port_r <= PORT_IF;   // IF "served last" so DP wins the first tie
      addr_r      <= {ADDR_W{1'b0}};
      size_r      <= SZ_BYTE;
      rw_r        <= 1'b1;
      wdata_r     <= 32'h0000_0000;
      idx_r       <= 2'd0;
      result_r    <= 32'h0000_0000;
      err_r       <= 1'b0;
      ram_en      <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= {ADDR_W{1'b0}};
      ram_wdata   <= 8'h00;
      if_moc      <= 1'b0;
      dp_moc      <= 1'b0;
      dp_err      <= 1'b0;
      if_rdata    <= 32'h0000_0000;
      dp_rdata    <= 32'h0000_0000;
    end else begin
      state_r     <= state_s;
      grant_r     <= grant_s;
      last_port_r <= last_port_s;
      addr_r      <= addr_s;
      size_r      <= size_s;
      rw_r        <= rw_s;
      wdata_r     <= wdata_s;
      idx_r       <= idx_s;
      result_r    <= result_s;
      err_r       <= err_s;
      ram_en      <= ram_en_s;
      ram_we      <= ram_we_s;
      ram_addr    <= ram_addr_s;
      ram_wdata   <= ram_wdata_s;
      if_moc      <= if_moc_s;
      dp_moc      <= dp_moc_s;
      dp_err      <= dp_err_s;
      if_rdata    <= if_rdata_s;
      dp_rdata    <= dp_rdata_s;
    end
  end

  // Next-state and datapath: arbitration, byte sequencing, read capture.
  always_comb begin
    state_s     = state_r;
    grant_s     = grant_r;
    last_port_s = last_port_r;
    addr_s      = addr_r;
    size_s      = size_r;
    rw_s        = rw_r;
    wdata_s     = wdata_r;
    idx_s       = idx_r;
    result_s    = result_r;
    err_s       = err_r;
    case (state_r)
      IDLE: begin
        if (if_req || dp_req) begin
          if (if_req && dp_req) begin
            grant_s = (last_port_r == PORT_DP) ? PORT_IF : PORT_DP;
          end else begin
            grant_s = dp_req ? PORT_DP : PORT_IF;
          end
          if (grant_s == PORT_DP) begin
            addr_s  = dp_addr;
            size_s  = dp_size;
            rw_s    = dp_rw;
            wdata_s = dp_wdata;
          end else begin
            addr_s  = if_addr;
            size_s  = SZ_WORD;
            rw_s    = 1'b1;
            wdata_s = 32'h0000_0000;
          end
          idx_s    = 2'd0;
          result_s = 32'h0000_0000;  // unread upper bytes give zero-extension
          if (access_legal(size_s, addr_s[1:0])) begin
            err_s   = 1'b0;
            state_s = ACCESS;
          end else begin
            err_s   = 1'b1;
            state_s = DONE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        if (wait_last_s) begin
          if (rw_r) begin
            result_s[{idx_r, 3'b000} +: 8] = ram_rdata;
          end else begin
            result_s = result_r;
          end
          if (idx_r == last_index(size_r)) begin
            state_s = DONE;
          end else begin
            idx_s = idx_r + 2'd1;
          end
        end else begin
          state_s = ACCESS;
        end
      end
      DONE: begin
        state_s     = RELEASE;
        last_port_s = grant_r;
      end
      RELEASE: begin
        // Wait for the served requester to drop req so a held req cannot retrigger.
        if (((grant_r == PORT_DP) ? dp_req : if_req) == 1'b0) begin
          state_s = IDLE;
        end else begin
          state_s = RELEASE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output decode from the next-state values, registered above.
  always_comb begin
    ram_en_s    = (state_s == ACCESS);
    ram_we_s    = ram_en_s && !rw_s;
    ram_addr_s  = ram_en_s ? (addr_s + ADDR_W'(idx_s)) : {ADDR_W{1'b0}};
    ram_wdata_s = ram_we_s ? get_byte(wdata_s, idx_s) : 8'h00;
    if_moc_s    = (state_s == DONE) && (grant_s == PORT_IF);
    dp_moc_s    = (state_s == DONE) && (grant_s == PORT_DP);
    dp_err_s    = dp_moc_s && err_s;
    if_rdata_s  = (if_moc_s && rw_s) ? result_s : if_rdata;
    dp_rdata_s  = (dp_moc_s && rw_s) ? result_s : dp_rdata;
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl: directed self-checking bench for ram_access_ctrl
// (WAIT_CYCLES=2, ADDR_W=8) with a behavioural 256x8 RAM.
module tb_ram_access_ctrl;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        if_req;
  logic [7:0]  if_addr;
  logic        if_moc;
  logic [31:0] if_rdata;
  logic        dp_req;
  logic        dp_rw;
  logic [1:0]  dp_size;
  logic [7:0]  dp_addr;
  logic [31:0] dp_wdata;
  logic        dp_moc;
  logic [31:0] dp_rdata;
  logic        dp_err;
  logic        ram_en;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  logic [7:0]  mem [256];

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  int          lat;
  logic        got_if, got_dp, err_seen;
  int          en_n, we_n, moc_n;
  logic [7:0]  we_addr;
  logic [7:0]  addr_log [16];
  logic        found;

  always #5 CLK = ~CLK;

  assign ram_rdata = mem[ram_addr];

  always @(posedge CLK) begin
    if (ram_en && ram_we) mem[ram_addr] = ram_wdata;
  end

  ram_access_ctrl #(.WAIT_CYCLES(2), .ADDR_W(8)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .if_req(if_req), .if_addr(if_addr), .if_moc(if_moc), .if_rdata(if_rdata),
    .dp_req(dp_req), .dp_rw(dp_rw), .dp_size(dp_size), .dp_addr(dp_addr),
    .dp_wdata(dp_wdata), .dp_moc(dp_moc), .dp_rdata(dp_rdata), .dp_err(dp_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge right after the request is driven; watches until the first moc.
  task automatic run_access(input int limit);
    lat = -1; got_if = 1'b0; got_dp = 1'b0; err_seen = 1'b0;
    en_n = 0; we_n = 0; we_addr = 8'h00;
    for (int n = 1; n <= limit && lat < 0; n++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (ram_en) begin
        if (en_n < 16) addr_log[en_n] = ram_addr;
        en_n++;
      end
      if (ram_we) begin
        we_n++;
        we_addr = ram_addr;
      end
      if (if_moc || dp_moc) begin
        lat = n; got_if = if_moc; got_dp = dp_moc; err_seen = dp_err;
      end
    end
  endtask

  task automatic drop_all();
    if_req = 1'b0;
    dp_req = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    RESET_N = 1'b0; if_req = 1'b0; if_addr = 8'h00;
    dp_req = 1'b0; dp_rw = 1'b1; dp_size = 2'b00; dp_addr = 8'h00; dp_wdata = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
    mem[8'h20] = 8'hA0; mem[8'h21] = 8'hA1; mem[8'h22] = 8'hA2; mem[8'h23] = 8'hA3;
    mem[8'h06] = 8'h3C;

    // Reset state
    #12;
    check("rst_ram_en", {31'd0, ram_en}, 32'd0);
    check("rst_ram_addr", {24'd0, ram_addr}, 32'd0);
    check("rst_moc_err", {29'd0, if_moc, dp_moc, dp_err}, 32'd0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_dp_rdata", dp_rdata, 32'h0);
    @(negedge CLK); RESET_N = 1'b1; @(negedge CLK);

    // Simultaneous requests after reset: DP first
    dp_req = 1'b1; dp_rw = 1'b1; dp_size = 2'b00; dp_addr = 8'h10;
    if_req = 1'b1; if_addr = 8'h20;
    run_access(40);
    check("arb1_dp_first", {30'd0, got_dp, got_if}, 32'd2);
    check("arb1_dp_lat", 32'(lat), 32'd3);
    check("arb1_dp_rdata", dp_rdata, 32'h0000_0011);
    dp_req = 1'b0;
    run_access(40);
    check("arb1_if_second", {30'd0, got_dp, got_if}, 32'd1);
    check("arb1_if_rdata", if_rdata, 32'hA3A2_A1A0);
    drop_all();

    // Both again: IF was served last, so DP wins
    dp_req = 1'b1; dp_addr = 8'h11; if_req = 1'b1; if_addr = 8'h20;
    run_access(40);
    check("arb2_dp_first", {30'd0, got_dp, got_if}, 32'd2);
    check("arb2_dp_rdata", dp_rdata, 32'h0000_0022);
    dp_req = 1'b0;
    run_access(40);
    check("arb2_if_second", {30'd0, got_dp, got_if}, 32'd1);
    drop_all();

    // IF word read at 0x10, then hold if_req past moc
    if_req = 1'b1; if_addr = 8'h10;
    run_access(40);
    check("ifw_lat", 32'(lat), 32'd9);
    check("ifw_rdata", if_rdata, 32'h4433_2211);
    check("ifw_en_cycles", 32'(en_n), 32'd8);
    for (int k = 0; k < 8; k++) check("ifw_addr_seq", {24'd0, addr_log[k]}, 32'h10 + 32'(k / 2));
    moc_n = 0; en_n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (if_moc || dp_moc) moc_n++;
      if (ram_en) en_n++;
    end
    check("hold_no_moc", 32'(moc_n), 32'd0);
    check("hold_no_en", 32'(en_n), 32'd0);
    drop_all();

    // DP byte write 0xA5 to 0x07
    dp_req = 1'b1; dp_rw = 1'b0; dp_size = 2'b00; dp_addr = 8'h07; dp_wdata = 32'hFFFF_FFA5;
    run_access(40);
    check("wr_lat", 32'(lat), 32'd3);
    check("wr_we_cycles", 32'(we_n), 32'd2);
    check("wr_we_addr", {24'd0, we_addr}, 32'h07);
    check("wr_err", {31'd0, err_seen}, 32'd0);
    check("wr_rdata_kept", dp_rdata, 32'h0000_0022);
    drop_all();

    // DP half read at 0x06
    dp_req = 1'b1; dp_rw = 1'b1; dp_size = 2'b01; dp_addr = 8'h06;
    run_access(40);
    check("half_lat", 32'(lat), 32'd5);
    check("half_rdata", dp_rdata, 32'h0000_A53C);
    check("half_err", {31'd0, err_seen}, 32'd0);
    drop_all();

    // Misaligned DP word at 0x02
    dp_req = 1'b1; dp_rw = 1'b1; dp_size = 2'b10; dp_addr = 8'h02;
    run_access(40);
    check("mis_lat", 32'(lat), 32'd1);
    check("mis_err", {31'd0, err_seen}, 32'd1);
    check("mis_no_en", 32'(en_n), 32'd0);
    drop_all();

    // Reserved size 11
    dp_req = 1'b1; dp_size = 2'b11; dp_addr = 8'h00;
    run_access(40);
    check("rsv_lat", 32'(lat), 32'd1);
    check("rsv_err", {31'd0, err_seen}, 32'd1);
    check("rsv_no_en", 32'(en_n), 32'd0);
    drop_all();

    // Reset during the 3rd byte of an IF word read
    if_req = 1'b1; if_addr = 8'h10; found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge CLK);
      if (ram_en && ram_addr == 8'h12) found = 1'b1;
    end
    check("rst_mid_reached", {31'd0, found}, 32'd1);
    RESET_N = 1'b0;
    #1;
    check("rst_mid_en", {31'd0, ram_en}, 32'd0);
    check("rst_mid_addr", {24'd0, ram_addr}, 32'd0);
    check("rst_mid_rdata", if_rdata, 32'h0);
    if_req = 1'b0;
    moc_n = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      if (if_moc || dp_moc) moc_n++;
    end
    check("rst_mid_no_moc", 32'(moc_n), 32'd0);
    RESET_N = 1'b1;
    @(negedge CLK);
    if_req = 1'b1; if_addr = 8'h10;
    run_access(40);
    check("post_rst_lat", 32'(lat), 32'd9);
    check("post_rst_rdata", if_rdata, 32'h4433_2211);
    drop_all();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
